// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
// Produces a 50%-duty divided clock for even and odd ratios plus a one-cycle
// enable strobe at every period start. Ratio changes and start/stop take
// effect only at period boundaries, so div_out never produces a runt pulse.
`timescale 1ns/1ps

module clk_div_prog #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DIV_INIT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_out,
  output logic             div_pulse,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_W-1:0] RATIO_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;
  logic             start;

  logic             val_ok;
  logic             load_ok;
  logic             period_end;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;

  // Load qualification and period bookkeeping helpers
  assign val_ok     = (div_val >= RATIO_MIN);
  assign load_ok    = div_load & val_ok;
  assign period_end = (cnt_q == (act_q - CNT_ONE));
  assign cnt_inc    = cnt_q + CNT_ONE;
  // Posedge high time: N/2 for even N, (N-1)/2 for odd N (negedge flop adds the half)
  assign half       = act_q >> 1;

  // Next-state, counter, ratio and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pos_d   = pos_q;
    pulse_d = 1'b0;
    err_d   = div_load & ~val_ok;
    start   = 1'b0;

    if (load_ok) begin
      pend_d = div_val;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        pos_d = 1'b0;
        if (en) begin
          start = 1'b1;
        end else if (load_ok) begin
          // No period running: a load is visible right away
          act_d = div_val;
        end
      end
      ST_RUN, ST_STOP: begin
        if (period_end) begin
          if (en) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pos_d   = 1'b0;
            act_d   = load_ok ? div_val : pend_q;
          end
        end else begin
          state_d = en ? ST_RUN : ST_STOP;
          cnt_d   = cnt_inc;
          pos_d   = (cnt_inc < half);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pos_d   = 1'b0;
      end
    endcase

    // Period start: adopt the pending ratio (a load on this edge waits one period)
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      act_d   = pend_q;
      pos_d   = 1'b1;
      pulse_d = 1'b1;
    end
  end

  // Posedge state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      act_q   <= RATIO_RST;
      pend_q  <= RATIO_RST;
      pos_q   <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  // Half-cycle delayed copy of the high phase, used to stretch odd ratios
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // neg_q is always low at a period boundary, so switching parity cannot glitch
  assign div_out   = pos_q | (neg_q & act_q[0]);
  assign div_pulse = pulse_q;
  assign div_cur   = act_q;
  assign load_err  = err_q;

endmodule
